// File: rtl/i2s_tx_multi.sv
// Slave-mode I2S / TDM transmitter: serialises CHANNELS samples per frame from external bit and
// LR clocks, with a one-frame holding buffer, underrun reporting and I2S or left-justified framing.
module i2s_tx_multi #(
    parameter int unsigned BIT_NUM   = 16,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned MODE      = 0
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic                        clock_bit,
    input  logic                        clock_lr,
    input  logic [BIT_NUM*CHANNELS-1:0] data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        data_out,
    output logic                        frame_start,
    output logic                        underrun
);
    localparam int unsigned FRAME_BITS = SLOT_BITS * CHANNELS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    logic                        bit_s1, bit_s2, bit_prev;
    logic                        lr_s1, lr_s2;
    logic                        lr_cap;
    logic                        bit_rise, bit_fall, cap_edge, start, accept;
    logic                        ready_en, hold_full;
    logic [BIT_NUM*CHANNELS-1:0] hold_buf;
    logic [FRAME_BITS-1:0]       shifter, load_word, shift_src;
    logic [CNT_W-1:0]            bit_cnt, cnt_src;

    assign bit_rise   = bit_s2 & ~bit_prev;
    assign bit_fall   = ~bit_s2 & bit_prev;
    // LR is sampled on the edge that defines the frame boundary for the selected framing.
    assign cap_edge   = (MODE == 0) ? bit_rise : bit_fall;
    assign start      = cap_edge & ~lr_s2 & lr_cap;
    assign data_ready = ready_en & ~hold_full;
    assign accept     = data_valid & data_ready;

    always_comb begin
        load_word = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            load_word[(CHANNELS - c) * SLOT_BITS - 1 -: BIT_NUM] =
                hold_buf[c * BIT_NUM +: BIT_NUM];
        end
    end

    // In left-justified mode the load and the first shift share a cycle, so both use these.
    always_comb begin
        shift_src = shifter;
        cnt_src   = bit_cnt;
        if (start) begin
            shift_src = hold_full ? load_word : '0;
            cnt_src   = '0;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            bit_s1      <= 1'b0;
            bit_s2      <= 1'b0;
            bit_prev    <= 1'b0;
            lr_s1       <= 1'b0;
            lr_s2       <= 1'b0;
            lr_cap      <= 1'b0;
            ready_en    <= 1'b0;
            hold_full   <= 1'b0;
            hold_buf    <= '0;
            shifter     <= '0;
            bit_cnt     <= '0;
            data_out    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            bit_s1      <= clock_bit;
            bit_s2      <= bit_s1;
            bit_prev    <= bit_s2;
            lr_s1       <= clock_lr;
            lr_s2       <= lr_s1;
            ready_en    <= 1'b1;
            frame_start <= start;
            underrun    <= start & ~hold_full;

            if (cap_edge) begin
                lr_cap <= lr_s2;
            end

            // A full buffer blocks accept, so on a frame start the flag simply follows accept.
            if (start) begin
                hold_full <= accept;
            end else if (accept) begin
                hold_full <= 1'b1;
            end
            if (accept) begin
                hold_buf <= data_in;
            end

            if (bit_fall) begin
                data_out <= shift_src[FRAME_BITS-1] & (cnt_src < FRAME_CNT);
                shifter  <= shift_src << 1;
                bit_cnt  <= (cnt_src == FRAME_CNT) ? cnt_src : cnt_src + CNT_W'(1);
            end else if (start) begin
                shifter <= shift_src;
                bit_cnt <= cnt_src;
            end
        end
    end

endmodule
